// File: rtl/phy_channel_pkg.sv
// -----------------------------------------------------------------------------
// phy_channel_pkg
// Shared definitions for the ping-pong capture channel:
//   - clog2 helper used to size channel/address/count fields
//   - default width constants for the reference configuration
//   - capture state enum
//   - 16-bit saturating frame-size helper
// No ports (package).
// -----------------------------------------------------------------------------
package phy_channel_pkg;

    // Ceiling log2. Used in constant context, so it stays a plain loop.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Width of a per-channel word count that can hold a full slot.
    function automatic int countWidth(input int slotDepth);
        return clog2(slotDepth) + 1;
    endfunction

    // Reference configuration and the widths derived from it.
    localparam int DEF_NUM_VCH    = 4;
    localparam int DEF_SLOT_DEPTH = 256;
    localparam int DEF_VCHN_W     = clog2(DEF_NUM_VCH);
    localparam int DEF_ADDR_W     = clog2(DEF_SLOT_DEPTH);
    localparam int DEF_OCNT_W     = countWidth(DEF_SLOT_DEPTH);
    localparam int SIZE_W         = 16;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_BUSY = 1'b1
    } capState_e;

    // Frame size is reported on 16 bits; larger totals pin at all-ones.
    function automatic logic [SIZE_W-1:0] satSize16(input logic [31:0] total);
        if (total > 32'h0000_FFFF) begin
            return 16'hFFFF;
        end
        return total[SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/phy_pp_ram.sv
// -----------------------------------------------------------------------------
// phy_pp_ram
// Simple dual-port RAM backing both halves of the ping-pong buffer.
// Depth 2^ADDR_W words of DATA_W bits, one write port, one registered read
// port (data appears one clock after the read address).
// Ports:
//   clk      in   clock for both ports
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data, 1-cycle latency
// -----------------------------------------------------------------------------
module phy_pp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // Contents are never reset; the read path is a plain registered lookup.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        rdData_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdData_q;

endmodule

// File: rtl/phy_channel_pp.sv
// -----------------------------------------------------------------------------
// phy_channel_pp
// Ping-pong frame buffer for NUM_VCH virtual channels. One half of the RAM is
// filled slot-by-slot from the accumulator stream while the other half is
// frozen for readout together with per-channel word counts, overrun flags and
// the total frame size.
//
// Optional feature: define PHY_CHANNEL_PP_CHKSUM_EN to add per-channel 16-bit
// modular checksums of the written words and the o_chksum port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_sync          start of full cycle, flips write half
//   i_slot_sync     start of one channel slot
//   i_wr_vchn       slot channel (sampled on i_slot_sync)
//   i_data_len      requested slot words (sampled on i_slot_sync)
//   i_in_vld        input word strobe
//   i_in_data       input word
//   i_complite      end of cycle, freeze write half for readout
//   i_rd_vchn       read channel select
//   i_rd_addr       read word address
//   o_rd_data       read data, 1-cycle latency
//   o_data_count    frozen count of i_rd_vchn (combinational)
//   o_out_size      NUM_VCH + sum of frozen counts, saturating 16-bit
//   o_frame_ready   frozen half valid
//   o_overrun       sticky per-channel overrun flags of the frozen frame
//   o_busy          slot capture active
//   o_chksum        frozen checksum of i_rd_vchn (feature build only)
// -----------------------------------------------------------------------------
module phy_channel_pp
    import phy_channel_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int NUM_VCH    = 4,
    parameter  int SLOT_DEPTH = 256,
    parameter  int LEN_W      = 10,
    localparam int VCHN_W     = clog2(NUM_VCH),
    localparam int ADDR_W     = clog2(SLOT_DEPTH),
    localparam int OCNT_W     = countWidth(SLOT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sync,
    input  logic               i_slot_sync,
    input  logic [VCHN_W-1:0]  i_wr_vchn,
    input  logic [LEN_W-1:0]   i_data_len,
    input  logic               i_in_vld,
    input  logic [DATA_W-1:0]  i_in_data,
    input  logic               i_complite,
    input  logic [VCHN_W-1:0]  i_rd_vchn,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0]  o_rd_data,
    output logic [OCNT_W-1:0]  o_data_count,
    output logic [SIZE_W-1:0]  o_out_size,
    output logic               o_frame_ready,
    output logic [NUM_VCH-1:0] o_overrun,
    output logic               o_busy
`ifdef PHY_CHANNEL_PP_CHKSUM_EN
    ,
    output logic [15:0]        o_chksum
`endif
);

    // Internal counts carry one extra bit over the length field so a slot
    // filled to SLOT_DEPTH is representable without wrapping.
    localparam int CNT_W  = LEN_W + 1;
    localparam int RAM_AW = 1 + VCHN_W + ADDR_W;

    // Write-side state
    logic                  flipHalf_q;
    capState_e             capState_q;
    logic [VCHN_W-1:0]     vchn_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [CNT_W-1:0]      effLen_q;
    logic [VCHN_W-1:0]     lastVchn_q;
    logic                  hasLast_q;
    logic [CNT_W-1:0]      cnt_q [NUM_VCH];
    logic [NUM_VCH-1:0]    ovr_q;

    // Frozen (read-side) state
    logic                  readHalf_q;
    logic [OCNT_W-1:0]     latCnt_q [NUM_VCH];
    logic [NUM_VCH-1:0]    latOvr_q;
    logic [SIZE_W-1:0]     outSize_q;
    logic                  frameReady_q;

    // Next-state helpers
    logic [CNT_W-1:0]      effLen_d;
    logic [CNT_W-1:0]      addrNext_d;
    logic [31:0]           sumAll_d;
    logic [SIZE_W-1:0]     outSize_d;
    logic                  ramWe;
    logic [RAM_AW-1:0]     ramWaddr;
    logic [RAM_AW-1:0]     ramRaddr;

    // Slot length is clamped to the physical slot so capture never spills
    // into the next channel's region.
    always_comb begin
        effLen_d = {1'b0, i_data_len};
        if ({1'b0, i_data_len} > CNT_W'(SLOT_DEPTH)) begin
            effLen_d = CNT_W'(SLOT_DEPTH);
        end
        addrNext_d = CNT_W'(addr_q) + CNT_W'(1);
    end

    // Frame size as it would be frozen right now: header words plus all
    // current counts, saturated to 16 bits.
    always_comb begin
        sumAll_d = 32'(NUM_VCH);
        for (int i = 0; i < NUM_VCH; i++) begin
            sumAll_d = sumAll_d + 32'(cnt_q[i]);
        end
        outSize_d = satSize16(sumAll_d);
    end

    // A word is stored only on a plain data cycle while a slot is open.
    assign ramWe    = !rst && !i_sync && !i_slot_sync && i_in_vld && (capState_q == CAP_BUSY);
    assign ramWaddr = {flipHalf_q, vchn_q, addr_q};
    assign ramRaddr = {readHalf_q, i_rd_vchn, i_rd_addr};

    // Capture/freeze control. i_complite snapshots the current registers, so
    // a same-cycle i_sync still freezes the pre-flip half. Within the write
    // side, i_sync beats i_slot_sync, which beats a data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            flipHalf_q   <= 1'b0;
            capState_q   <= CAP_IDLE;
            vchn_q       <= '0;
            addr_q       <= '0;
            effLen_q     <= '0;
            lastVchn_q   <= '0;
            hasLast_q    <= 1'b0;
            ovr_q        <= '0;
            readHalf_q   <= 1'b0;
            latOvr_q     <= '0;
            outSize_q    <= '0;
            frameReady_q <= 1'b0;
            for (int i = 0; i < NUM_VCH; i++) begin
                cnt_q[i]    <= '0;
                latCnt_q[i] <= '0;
            end
        end else begin
            if (i_complite) begin
                readHalf_q <= flipHalf_q;
                latOvr_q   <= ovr_q;
                outSize_q  <= outSize_d;
                for (int i = 0; i < NUM_VCH; i++) begin
                    latCnt_q[i] <= OCNT_W'(cnt_q[i]);
                end
            end

            if (i_sync) begin
                frameReady_q <= 1'b0;
            end else if (i_complite) begin
                frameReady_q <= 1'b1;
            end

            if (i_sync) begin
                flipHalf_q <= ~flipHalf_q;
                capState_q <= CAP_IDLE;
                hasLast_q  <= 1'b0;
                ovr_q      <= '0;
                for (int i = 0; i < NUM_VCH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (i_slot_sync) begin
                // An unfinished slot keeps what it got and is marked overrun.
                if (capState_q == CAP_BUSY) begin
                    cnt_q[vchn_q] <= CNT_W'(addr_q);
                    ovr_q[vchn_q] <= 1'b1;
                end
                addr_q   <= '0;
                vchn_q   <= i_wr_vchn;
                effLen_q <= effLen_d;
                if (effLen_d != '0) begin
                    capState_q <= CAP_BUSY;
                    lastVchn_q <= i_wr_vchn;
                    hasLast_q  <= 1'b1;
                end else begin
                    capState_q <= CAP_IDLE;
                end
            end else if (i_in_vld) begin
                if (capState_q == CAP_BUSY) begin
                    if (addrNext_d == effLen_q) begin
                        cnt_q[vchn_q] <= addrNext_d;
                        capState_q    <= CAP_IDLE;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end else if (hasLast_q) begin
                    // Surplus words are charged to the most recent real slot.
                    ovr_q[lastVchn_q] <= 1'b1;
                end
            end
        end
    end

`ifdef PHY_CHANNEL_PP_CHKSUM_EN
    logic [15:0] chk_q    [NUM_VCH];
    logic [15:0] latChk_q [NUM_VCH];

    // Checksums follow the counts: cleared on i_sync, frozen on i_complite,
    // accumulated on exactly the words that reach the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VCH; i++) begin
                chk_q[i]    <= '0;
                latChk_q[i] <= '0;
            end
        end else begin
            if (i_complite) begin
                for (int i = 0; i < NUM_VCH; i++) begin
                    latChk_q[i] <= chk_q[i];
                end
            end
            if (i_sync) begin
                for (int i = 0; i < NUM_VCH; i++) begin
                    chk_q[i] <= '0;
                end
            end else if (ramWe) begin
                chk_q[vchn_q] <= chk_q[vchn_q] + 16'(i_in_data);
            end
        end
    end

    assign o_chksum = latChk_q[i_rd_vchn];
`endif

    phy_pp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (ramWe),
        .i_waddr (ramWaddr),
        .i_wdata (i_in_data),
        .i_raddr (ramRaddr),
        .o_rdata (o_rd_data)
    );

    assign o_data_count  = latCnt_q[i_rd_vchn];
    assign o_out_size    = outSize_q;
    assign o_frame_ready = frameReady_q;
    assign o_overrun     = latOvr_q;
    assign o_busy        = (capState_q == CAP_BUSY);

endmodule

// File: tb/tb_phy_channel_pp.sv
// -----------------------------------------------------------------------------
// tb_phy_channel_pp
// Self-checking bench for phy_channel_pp in its default configuration.
// Read data expectations are queued when a read address is driven and
// compared when the registered read data appears.
// -----------------------------------------------------------------------------
module tb_phy_channel_pp;

    localparam int DATA_W     = 32;
    localparam int NUM_VCH    = 4;
    localparam int SLOT_DEPTH = 256;
    localparam int LEN_W      = 10;
    localparam int VCHN_W     = 2;
    localparam int ADDR_W     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_sync;
    logic              i_slot_sync;
    logic [VCHN_W-1:0] i_wr_vchn;
    logic [LEN_W-1:0]  i_data_len;
    logic              i_in_vld;
    logic [DATA_W-1:0] i_in_data;
    logic              i_complite;
    logic [VCHN_W-1:0] i_rd_vchn;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic [ADDR_W:0]   o_data_count;
    logic [15:0]       o_out_size;
    logic              o_frame_ready;
    logic [NUM_VCH-1:0] o_overrun;
    logic              o_busy;
`ifdef PHY_CHANNEL_PP_CHKSUM_EN
    logic [15:0]       o_chksum;
`endif

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] expQ [$];

    always #5 clk = ~clk;

    phy_channel_pp #(
        .DATA_W     (DATA_W),
        .NUM_VCH    (NUM_VCH),
        .SLOT_DEPTH (SLOT_DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_sync        (i_sync),
        .i_slot_sync   (i_slot_sync),
        .i_wr_vchn     (i_wr_vchn),
        .i_data_len    (i_data_len),
        .i_in_vld      (i_in_vld),
        .i_in_data     (i_in_data),
        .i_complite    (i_complite),
        .i_rd_vchn     (i_rd_vchn),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_data_count  (o_data_count),
        .o_out_size    (o_out_size),
        .o_frame_ready (o_frame_ready),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
`ifdef PHY_CHANNEL_PP_CHKSUM_EN
        ,
        .o_chksum      (o_chksum)
`endif
    );

    // Distinct word per (frame tag, channel, index) so misplaced data shows up.
    function automatic logic [31:0] dataWord(input int tag, input int vch, input int idx);
        logic [31:0] t, v, x;
        t = tag;
        v = vch;
        x = idx;
        return {t[7:0], v[7:0], x[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one clock worth of write-side inputs (called at a negedge,
    // returns at the next negedge).
    task automatic applyStimulus(input logic sync, input logic slot, input int vch,
                                 input int len, input logic vld,
                                 input logic [31:0] data, input logic complite);
        i_sync      = sync;
        i_slot_sync = slot;
        i_wr_vchn   = VCHN_W'(vch);
        i_data_len  = LEN_W'(len);
        i_in_vld    = vld;
        i_in_data   = data;
        i_complite  = complite;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic runSlot(input int vch, input int len, input int nWords, input int tag);
        applyStimulus(1'b0, 1'b1, vch, len, 1'b0, '0, 1'b0);
        checkOutput($sformatf("busyStart%0d", vch), 64'(o_busy), 64'(len != 0));
        for (int i = 0; i < nWords; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, dataWord(tag, vch, i), 1'b0);
        end
    endtask

    task automatic checkCount(input int vch, input int expCnt);
        i_rd_vchn = VCHN_W'(vch);
        #1;
        checkOutput($sformatf("count%0d", vch), 64'(o_data_count), 64'(expCnt));
    endtask

    // Present one read address and compare the word it returns one clock later.
    task automatic readCheck(input int vch, input int addr, input logic [31:0] expData);
        i_rd_vchn = VCHN_W'(vch);
        i_rd_addr = ADDR_W'(addr);
        expQ.push_back(expData);
        idleCycle();
        checkOutput($sformatf("rd%0d_%0d", vch, addr), 64'(o_rd_data), 64'(expQ.pop_front()));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_sync = 0; i_slot_sync = 0; i_wr_vchn = '0; i_data_len = '0;
        i_in_vld = 0; i_in_data = '0; i_complite = 0; i_rd_vchn = '0; i_rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rstReady", 64'(o_frame_ready), 64'd0);
        checkOutput("rstSize", 64'(o_out_size), 64'd0);
        checkOutput("rstOvr", 64'(o_overrun), 64'd0);
        checkOutput("rstBusy", 64'(o_busy), 64'd0);
        checkCount(0, 0);

        // Full frame: lengths 10,20,0,256 with 300 strobes per slot
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, '0, 1'b0);
        runSlot(0, 10, 300, 1);
        runSlot(1, 20, 300, 1);
        runSlot(2, 0, 300, 1);
        runSlot(3, 256, 300, 1);
        checkOutput("busyAfterFull", 64'(o_busy), 64'd0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
        checkOutput("ready1", 64'(o_frame_ready), 64'd1);
        checkOutput("size1", 64'(o_out_size), 64'd290);
        checkOutput("ovr1", 64'(o_overrun), 64'b1011);
        checkCount(0, 10);
        checkCount(1, 20);
        checkCount(2, 0);
        checkCount(3, 256);

        // Read frozen vch3 while filling the other half with different data
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, '0, 1'b0);
        checkOutput("readyCleared", 64'(o_frame_ready), 64'd0);
        runSlot(3, 256, 0, 2);
        for (int a = 0; a < 256; a++) begin
            i_rd_vchn = 2'd3;
            i_rd_addr = ADDR_W'(a);
            expQ.push_back(dataWord(1, 3, a));
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, dataWord(2, 3, a), 1'b0);
            checkOutput($sformatf("rdPP%0d", a), 64'(o_rd_data), 64'(expQ.pop_front()));
        end
        checkOutput("busyAfterPP", 64'(o_busy), 64'd0);

        // Aborted slot on vch1, then a normal vch2 slot
        runSlot(1, 50, 30, 3);
        runSlot(2, 5, 5, 3);
        checkOutput("busyAfterV2", 64'(o_busy), 64'd0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
        checkOutput("ready2", 64'(o_frame_ready), 64'd1);
        checkOutput("size2", 64'(o_out_size), 64'd295);
        checkOutput("ovr2", 64'(o_overrun), 64'b0010);
        checkCount(0, 0);
        checkCount(1, 30);
        checkCount(2, 5);
        checkCount(3, 256);
        for (int a = 0; a < 5; a++) begin
            readCheck(2, a, dataWord(3, 2, a));
        end
        readCheck(1, 29, dataWord(3, 1, 29));
        readCheck(3, 255, dataWord(2, 3, 255));

        // i_sync together with i_complite freezes the pre-flip half
        runSlot(0, 7, 7, 4);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, '0, 1'b1);
        checkOutput("readyBoth", 64'(o_frame_ready), 64'd0);
        checkOutput("sizeBoth", 64'(o_out_size), 64'd302);
        checkOutput("ovrBoth", 64'(o_overrun), 64'b0010);
        checkCount(0, 7);
        checkCount(1, 30);
        readCheck(0, 6, dataWord(4, 0, 6));

        // Oversized request clamps to a full slot
        runSlot(0, 1023, 300, 5);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
        checkCount(0, 256);
        checkCount(1, 0);
        checkOutput("sizeClamp", 64'(o_out_size), 64'd260);
        checkOutput("ovrClamp", 64'(o_overrun), 64'b0001);

        // Reset in the middle of a slot
        runSlot(1, 100, 20, 6);
        checkOutput("busyMid", 64'(o_busy), 64'd1);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("busyRst", 64'(o_busy), 64'd0);
        checkOutput("sizeRst", 64'(o_out_size), 64'd0);
        checkOutput("readyRst", 64'(o_frame_ready), 64'd0);
        checkOutput("ovrRst", 64'(o_overrun), 64'd0);
        checkCount(0, 0);

`ifdef PHY_CHANNEL_PP_CHKSUM_EN
        // Checksum of words 1..10 on vch0
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 10, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 32'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
        i_rd_vchn = 2'd0;
        #1;
        checkOutput("chksum0", 64'(o_chksum), 64'd55);
        checkCount(0, 10);
`endif

        idleCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phy_channel_pp.md
Name: phy_channel_pp

Overview:
- Parametrised successor of the single-clock capture channel: a ping-pong frame buffer for N virtual channels with configurable data width and slot depth.
- Sits between the ADC accumulator (valid/data stream) and the frame readout / packetiser.
- While one half is written slot-by-slot, the other half is frozen for readout, with per-channel word counts and total frame size.
- Adds slot-abort and overrun status that the previous generation lacks.

Parameters:
- DATA_W, 32, width of one accumulated sample word.
- NUM_VCH, 4, number of virtual channels; power of two, 2..16.
- SLOT_DEPTH, 256, maximum words per channel slot; power of two, 16..1024.
- LEN_W, 10, width of the requested slot length; must satisfy 2^LEN_W >= SLOT_DEPTH.

Ports:
- clk  in  1  single clock for write and read sides.
- rst  in  1  synchronous reset, active-high.
- i_sync  in  1  start of full cycle; flips write half.
- i_slot_sync  in  1  start of one channel slot.
- i_wr_vchn  in  log2(NUM_VCH)  channel of the current slot; sampled on i_slot_sync.
- i_data_len  in  LEN_W  requested words for the slot; sampled on i_slot_sync.
- i_in_vld  in  1  input word strobe.
- i_in_data  in  DATA_W  input word.
- i_complite  in  1  end of cycle; freeze write half for readout.
- i_rd_vchn  in  log2(NUM_VCH)  read channel select.
- i_rd_addr  in  log2(SLOT_DEPTH)  read word address.
- o_rd_data  out  DATA_W  read data, 1-cycle latency.
- o_data_count  out  log2(SLOT_DEPTH)+1  frozen count for i_rd_vchn; combinational.
- o_out_size  out  16  NUM_VCH + sum of frozen counts.
- o_frame_ready  out  1  frozen half valid.
- o_overrun  out  NUM_VCH  sticky per-channel flag for the frozen frame.
- o_busy  out  1  slot capture active.

Behaviour:
- Reset values:
  - All outputs 0 except o_rd_data, which is don't-care until the first read.
  - flip_half=0; all counts, latched counts and overrun flags 0; capture idle.
- Priority per cycle: i_sync > i_slot_sync > write.
  - i_complite is evaluated independently and samples state before any same-cycle flip.
- i_sync:
  - flip_half <= ~flip_half.
  - Counts and overrun flags of the half about to be written are cleared.
  - Any active capture is aborted; its partial count is not recorded.
  - A same-cycle i_slot_sync is ignored.
- i_slot_sync:
  - addr <= 0; vchn and len are latched.
  - Effective length = min(len, SLOT_DEPTH).
  - len=0: o_busy stays 0, count remains 0.
  - If a capture was still active, that channel's count <= addr (words written so far) and its overrun flag is set.
- Capture:
  - While busy and i_in_vld, the word is written to RAM address {flip_half, vchn, addr}.
  - On the last word (addr+1 == effective length): count <= addr+1, busy <= 0.
  - Otherwise addr increments.
  - i_in_vld while not busy is dropped; the channel last captured gets its overrun flag set. Before any slot this cycle, nothing is flagged.
- Counts are LEN_W+1 wide internally so a full SLOT_DEPTH slot is representable, with no wrap.
- i_complite:
  - Read half <= flip_half.
  - Latched counts, overrun flags and o_out_size update on the next edge.
  - Sum arithmetic is 16-bit unsigned and saturates at 16'hFFFF.
- o_frame_ready: cleared by i_sync, set by i_complite; i_sync wins if simultaneous.
- Read:
  - RAM read address is {read_half, i_rd_vchn, i_rd_addr}, registered.
  - o_rd_data is valid 1 cycle after the address is presented.
  - Reads of addresses >= count return stale RAM contents (unspecified).
- rst mid-capture: capture aborts and all state clears within the same edge; RAM contents are not cleared.

Optional Feature:
- Macro: PHY_CHANNEL_PP_CHKSUM_EN.
- Enabled:
  - Per-channel 16-bit modular sum of the low 16 bits of every written word is accumulated in the write half.
  - Sums are cleared with the counts on i_sync and latched on i_complite.
  - Extra port o_chksum[15:0] presents the latched sum for i_rd_vchn.
- Disabled: no accumulators and no o_chksum port.

Decomposition:
- Package phy_channel_pkg holds:
  - clog2 helper;
  - vchn/addr/count width constants derived from NUM_VCH and SLOT_DEPTH;
  - 16-bit size saturation function.
- One sub-module, phy_pp_ram: simple dual-port RAM, depth 2*NUM_VCH*SLOT_DEPTH, width DATA_W, registered read, write-enable qualified.

Test Plan:
- Defaults. Sync; slots vch0..3 with len 10,20,0,256; 300 vld words each; complite.
  - Expected: counts 10,20,0,256; o_out_size=290; frame_ready=1; overrun=4'b1011 (extra valids after vch0/1/3 completed; vch2 len=0 gives no capture, so its flag stays 0).
- vch1 len=50, only 30 words, then slot_sync for vch2.
  - Expected: count1=30, overrun[1]=1, vch2 captures normally.
- Read back vch3 addr 0..255 after complite.
  - Expected: o_rd_data equals the written data, 1-cycle latency.
  - Simultaneously write the other half with different data; the readout is unchanged.
- i_sync and i_complite in the same cycle.
  - Expected: the latched counts come from the pre-flip half; frame_ready=0 the next cycle.
- len=1023 with SLOT_DEPTH=256: clamps, count=256; rst asserted mid-slot clears counts and o_busy the next cycle.
- With PHY_CHANNEL_PP_CHKSUM_EN: write words 1..10 to vch0.
  - Expected: o_chksum=55 after complite.
